rr_arb_mux_4: RTL

//  Round-robin arbiter that shares one 4:1 data mux between four valid/ready requesters.

---
 rtl/rr_arb_mux_pkg.sv | 16 +
 rtl/rr_pick_4.sv | 37 +++
 rtl/rr_arb_mux_4.sv | 92 +++++++++
 3 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter/mux.
package rr_arb_mux_pkg;

  localparam int unsigned N_REQ = 4;

  typedef logic [1:0] req_idx_t;

  // Decode a requester index into a 4-bit one-hot vector.
  function automatic logic [N_REQ-1:0] onehot4(req_idx_t idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: rotate requests so the slot after `last`
// sits at bit 0, priority-encode the lowest set bit, then rotate the index back.
module rr_pick_4
  import rr_arb_mux_pkg::*;
(
  input  logic [3:0] req,
  input  req_idx_t   last,
  output req_idx_t   gnt_idx,
  output logic       gnt_any
);

  req_idx_t   start;
  logic [3:0] rot;
  req_idx_t   enc;

  assign start = last + 2'd1;

  // Rotate: rot[i] is the requester i slots after start (2-bit add wraps).
  always_comb begin
    rot = '0;
    for (int i = 0; i < 4; i++) begin
      rot[i] = req[start + req_idx_t'(i)];
    end
  end

  // Priority-encode: lowest set bit of the rotated vector wins.
  always_comb begin
    enc = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) enc = req_idx_t'(i);
    end
  end

  assign gnt_any = |req;
  assign gnt_idx = start + enc;

endmodule

// File: rtl/rr_arb_mux_4.sv
// Round-robin arbiter sharing one 4:1 data mux between four valid/ready
// requesters, feeding a one-entry registered output stage.
// Optional burst lock: define RR_ARB_MUX_BURST_LOCK_EN to add in_last and
// hold the grant on one requester until its last beat is accepted.
module rr_arb_mux_4
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
`ifdef RR_ARB_MUX_BURST_LOCK_EN
  input  logic [3:0]     in_last,
`endif
  output logic [3:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_sel,
  input  logic           out_ready
);

  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  req_idx_t       out_sel_q;
  req_idx_t       last_q;

  logic [3:0]     eff_req;
  req_idx_t       gnt_idx;
  logic           gnt_any;
  logic           accept;
  logic           fire;
  logic [W-1:0]   mux_data;

`ifdef RR_ARB_MUX_BURST_LOCK_EN
  logic           lock_q;

  // While locked only the owner (held in last_q) may be granted.
  assign eff_req = lock_q ? (in_valid & onehot4(last_q)) : in_valid;

  // Lock engages on a non-last accepted beat and releases on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (fire) begin
      lock_q <= ~in_last[gnt_idx];
    end
  end
`else
  assign eff_req = in_valid;
`endif

  rr_pick_4 u_pick (
    .req     (eff_req),
    .last    (last_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign accept   = ~out_valid_q | out_ready;
  // Reset gates the handshake so no beat is taken while the stage is cleared.
  assign fire     = accept & gnt_any & ~rst;
  assign in_ready = onehot4(gnt_idx) & {4{fire}};

  // Shared data mux steered by the grant index.
  always_comb begin
    mux_data = in_data[gnt_idx*W +: W];
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      last_q      <= 2'd3;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mux_data;
      out_sel_q   <= gnt_idx;
      last_q      <= gnt_idx;
    end else if (accept) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
